// File: rtl/interp_pkg.sv
// rtl/interp_pkg.sv - shared types and helpers for the linear interpolation upsampler
package interp_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RAMP = 1'b1
    } interp_state_t;

    localparam int unsigned DEFAULT_SIGNALWIDTH = 16;
    localparam int unsigned DEFAULT_STEPBITS    = 8;
    localparam int unsigned DEFAULT_N           = 32'd1 << DEFAULT_STEPBITS;

    // Offset-binary zero level for a bus of the given width.
    function automatic int unsigned midscale(input int unsigned width);
        return 32'd1 << (width - 1);
    endfunction

    // Number of clocks a segment takes to reach its target.
    function automatic int unsigned n_steps(input int unsigned stepbits);
        return 32'd1 << stepbits;
    endfunction

endpackage

// File: rtl/linear_interp_upsampler_if.sv
// rtl/linear_interp_upsampler_if.sv - sample input handshake between producer and upsampler
interface linear_interp_upsampler_if #(
    parameter int signalwidth = 16
);
    logic [signalwidth-1:0] in_d;
    logic                   in_valid;
    logic                   in_ready;

    modport master (
        output in_d,
        output in_valid,
        input  in_ready
    );

    modport slave (
        input  in_d,
        input  in_valid,
        output in_ready
    );
endinterface

// File: rtl/interp_sample_buffer.sv
// rtl/interp_sample_buffer.sv - one-entry sample holding register with valid/ready handshake
module interp_sample_buffer #(
    parameter int signalwidth = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [signalwidth-1:0] in_d,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   pop,
    output logic [signalwidth-1:0] buf_data,
    output logic                   buf_valid
);

    // Ready only while empty; a pop frees the slot for the following cycle.
    assign in_ready = !buf_valid;

    // Capture on transfer, release on pop (the two never coincide: pop needs a full slot).
    always_ff @(posedge clk) begin
        if (reset) begin
            buf_data  <= '0;
            buf_valid <= 1'b0;
        end else if (in_valid && in_ready) begin
            buf_data  <= in_d;
            buf_valid <= 1'b1;
        end else if (pop) begin
            buf_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/linear_interp_upsampler.sv
// rtl/linear_interp_upsampler.sv - linear ramp between consecutive samples, feeding a DAC d input
module linear_interp_upsampler
    import interp_pkg::*;
#(
    parameter int signalwidth = 16,
    parameter int stepbits    = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    linear_interp_upsampler_if.slave      s_in,
    output logic [signalwidth-1:0]        q,
    output logic                          underrun
);

    localparam int AW = signalwidth + stepbits;
    localparam int unsigned N = n_steps(stepbits);
    localparam logic [signalwidth-1:0] MID = signalwidth'(midscale(signalwidth));

    interp_state_t           state, state_next;
    logic [AW-1:0]           acc, acc_next, acc_sum;
    logic signed [signalwidth:0] delta, delta_next, seg_delta;
    logic signed [AW-1:0]    delta_ext;
    logic [stepbits-1:0]     phase, phase_next;
    logic [signalwidth-1:0]  target, target_next;
    logic                    underrun_next;
    logic                    last_step;
    logic                    pop;
    logic [signalwidth-1:0]  buf_data;
    logic                    buf_valid;

    interp_sample_buffer #(
        .signalwidth(signalwidth)
    ) u_buf (
        .clk      (clk),
        .reset    (reset),
        .in_d     (s_in.in_d),
        .in_valid (s_in.in_valid),
        .in_ready (s_in.in_ready),
        .pop      (pop),
        .buf_data (buf_data),
        .buf_valid(buf_valid)
    );

    // The per-clock increment is the segment difference; N additions land exactly on target.
    assign delta_ext = AW'(delta);
    assign acc_sum   = acc + $unsigned(delta_ext);
    assign seg_delta = $signed({1'b0, buf_data}) - $signed({1'b0, target});
    assign last_step = (phase == stepbits'(N - 1));
    assign q         = acc[AW-1:stepbits];

    // Next-state and datapath decisions: load a new segment, step the ramp, or flag an underrun.
    always_comb begin
        state_next    = state;
        acc_next      = acc;
        phase_next    = phase;
        target_next   = target;
        delta_next    = delta;
        underrun_next = 1'b0;
        pop           = 1'b0;
        case (state)
            IDLE: begin
                if (buf_valid) begin
                    target_next = buf_data;
                    delta_next  = seg_delta;
                    phase_next  = '0;
                    pop         = 1'b1;
                    state_next  = RAMP;
                end
            end
            RAMP: begin
                acc_next   = acc_sum;
                phase_next = phase + 1'b1;
                if (last_step) begin
                    if (buf_valid) begin
                        target_next = buf_data;
                        delta_next  = seg_delta;
                        pop         = 1'b1;
                    end else begin
                        delta_next    = '0;
                        underrun_next = 1'b1;
                        state_next    = IDLE;
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Register the FSM and datapath; reset parks the output at midscale.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            acc      <= {MID, {stepbits{1'b0}}};
            phase    <= '0;
            target   <= MID;
            delta    <= '0;
            underrun <= 1'b0;
        end else begin
            state    <= state_next;
            acc      <= acc_next;
            phase    <= phase_next;
            target   <= target_next;
            delta    <= delta_next;
            underrun <= underrun_next;
        end
    end

endmodule
